rs_age_select: RTL

Parametrised N-way reservation station with age-ordered multi-issue. It sits between rename/dispatch and the execute lanes of the R10K-style core and generalises the fixed-width dispatch/issue glue. It accepts up to WAYS renamed instructions per cycle and wakes operands from CDB broadcasts. Each cycle it selects up to ISSUE oldest ready entries for issue under a per-lane ready/valid handshake. A full flush empties it.

---
 rtl/rs_age_select.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/rs_age_select.sv
// rs_age_select: N-way reservation station with age-matrix ordered multi-issue select.
// Issue outputs are combinational from registered state; dispatch accepts a prefix of valid lanes.
module rs_age_select #(
  parameter int WAYS  = 2,
  parameter int ISSUE = 2,
  parameter int CDB   = 2,
  parameter int DEPTH = 16,
  parameter int TAG_W = 6,
  parameter int OP_W  = 7
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_flush,
  input  logic [WAYS-1:0]            i_disp_valid,
  input  logic [WAYS*OP_W-1:0]       i_disp_op,
  input  logic [WAYS*TAG_W-1:0]      i_disp_src1,
  input  logic [WAYS*TAG_W-1:0]      i_disp_src2,
  input  logic [WAYS-1:0]            i_disp_rdy1,
  input  logic [WAYS-1:0]            i_disp_rdy2,
  input  logic [WAYS*TAG_W-1:0]      i_disp_dest,
  output logic [WAYS-1:0]            o_disp_accept,
  output logic [$clog2(DEPTH):0]     o_free_cnt,
  input  logic [CDB-1:0]             i_cdb_valid,
  input  logic [CDB*TAG_W-1:0]       i_cdb_tag,
  output logic [ISSUE-1:0]           o_iss_valid,
  input  logic [ISSUE-1:0]           i_iss_ready,
  output logic [ISSUE*OP_W-1:0]      o_iss_op,
  output logic [ISSUE*TAG_W-1:0]     o_iss_src1,
  output logic [ISSUE*TAG_W-1:0]     o_iss_src2,
  output logic [ISSUE*TAG_W-1:0]     o_iss_dest
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] r_busy, r_rdy1, r_rdy2;
  logic [OP_W-1:0]  r_op   [DEPTH];
  logic [TAG_W-1:0] r_src1 [DEPTH];
  logic [TAG_W-1:0] r_src2 [DEPTH];
  logic [TAG_W-1:0] r_dest [DEPTH];
  // r_older[a][b] is set when entry a was written before entry b
  logic [DEPTH-1:0] r_older [DEPTH];

  logic [CW-1:0]    w_free_cnt;
  logic [DEPTH-1:0] w_slot   [WAYS];
  logic [DEPTH-1:0] w_lower  [WAYS];
  logic [DEPTH-1:0] w_higher [WAYS];
  logic [DEPTH-1:0] w_cand;
  logic [CW-1:0]    w_rank   [DEPTH];
  logic [DEPTH-1:0] w_iss_sel [ISSUE];
  logic [DEPTH-1:0] w_fire;

  function automatic logic f_hit(input logic [TAG_W-1:0] tag,
                                 input logic [CDB-1:0] vld,
                                 input logic [CDB*TAG_W-1:0] tags);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < CDB; k++)
      if (vld[k] && tags[k*TAG_W +: TAG_W] == tag) hit = 1'b1;
    return hit && (tag != '0);
  endfunction

  always_comb begin
    w_free_cnt = '0;
    for (int e = 0; e < DEPTH; e++) w_free_cnt = w_free_cnt + CW'(~r_busy[e]);
  end
  assign o_free_cnt = w_free_cnt;

  // Accepted lanes take the lowest free entries in lane order; a rejected valid lane blocks the rest.
  always_comb begin
    logic             blocked;
    logic             found;
    logic [CW-1:0]    n;
    logic [DEPTH-1:0] avail;
    blocked       = 1'b0;
    found         = 1'b0;
    n             = '0;
    avail         = ~r_busy;
    o_disp_accept = '0;
    for (int i = 0; i < WAYS; i++) begin
      w_slot[i] = '0;
      if (i_disp_valid[i] && !blocked && !i_flush && n < w_free_cnt) begin
        o_disp_accept[i] = 1'b1;
        n     = n + CW'(1);
        found = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
          if (avail[e] && !found) begin
            w_slot[i][e] = 1'b1;
            avail[e]     = 1'b0;
            found        = 1'b1;
          end
        end
      end else if (i_disp_valid[i]) begin
        blocked = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WAYS; i++) begin
      w_lower[i]  = '0;
      w_higher[i] = '0;
      for (int k = 0; k < WAYS; k++) begin
        if (k < i)      w_lower[i]  = w_lower[i]  | w_slot[k];
        else if (k > i) w_higher[i] = w_higher[i] | w_slot[k];
      end
    end
  end

  // Rank of a candidate = number of older candidates; lane j takes rank j.
  always_comb begin
    w_cand = r_busy & r_rdy1 & r_rdy2;
    for (int e = 0; e < DEPTH; e++) begin
      w_rank[e] = '0;
      for (int a = 0; a < DEPTH; a++)
        w_rank[e] = w_rank[e] + CW'(w_cand[a] & r_older[a][e]);
    end
  end

  always_comb begin
    o_iss_valid = '0;
    o_iss_op    = '0;
    o_iss_src1  = '0;
    o_iss_src2  = '0;
    o_iss_dest  = '0;
    for (int j = 0; j < ISSUE; j++) begin
      w_iss_sel[j] = '0;
      for (int e = 0; e < DEPTH; e++) begin
        if (w_cand[e] && w_rank[e] == CW'(j)) begin
          w_iss_sel[j][e]             = 1'b1;
          o_iss_valid[j]              = !i_flush;
          o_iss_op[j*OP_W +: OP_W]    = r_op[e];
          o_iss_src1[j*TAG_W +: TAG_W] = r_src1[e];
          o_iss_src2[j*TAG_W +: TAG_W] = r_src2[e];
          o_iss_dest[j*TAG_W +: TAG_W] = r_dest[e];
        end
      end
    end
  end

  always_comb begin
    w_fire = '0;
    for (int j = 0; j < ISSUE; j++)
      if (o_iss_valid[j] && i_iss_ready[j]) w_fire = w_fire | w_iss_sel[j];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
      r_rdy1 <= '0;
      r_rdy2 <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        r_op[e]    <= '0;
        r_src1[e]  <= '0;
        r_src2[e]  <= '0;
        r_dest[e]  <= '0;
        r_older[e] <= '0;
      end
    end else if (i_flush) begin
      r_busy <= '0;
      for (int e = 0; e < DEPTH; e++) r_older[e] <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if (r_busy[e] && f_hit(r_src1[e], i_cdb_valid, i_cdb_tag)) r_rdy1[e] <= 1'b1;
        if (r_busy[e] && f_hit(r_src2[e], i_cdb_valid, i_cdb_tag)) r_rdy2[e] <= 1'b1;
        if (w_fire[e]) r_busy[e] <= 1'b0;
      end
      // New entries are younger than all busy entries and than lower lanes of the same cycle.
      for (int i = 0; i < WAYS; i++) begin
        for (int e = 0; e < DEPTH; e++) begin
          if (w_slot[i][e]) begin
            r_busy[e] <= 1'b1;
            r_op[e]   <= i_disp_op[i*OP_W +: OP_W];
            r_src1[e] <= i_disp_src1[i*TAG_W +: TAG_W];
            r_src2[e] <= i_disp_src2[i*TAG_W +: TAG_W];
            r_dest[e] <= i_disp_dest[i*TAG_W +: TAG_W];
            r_rdy1[e] <= i_disp_rdy1[i] || (i_disp_src1[i*TAG_W +: TAG_W] == '0) ||
                         f_hit(i_disp_src1[i*TAG_W +: TAG_W], i_cdb_valid, i_cdb_tag);
            r_rdy2[e] <= i_disp_rdy2[i] || (i_disp_src2[i*TAG_W +: TAG_W] == '0) ||
                         f_hit(i_disp_src2[i*TAG_W +: TAG_W], i_cdb_valid, i_cdb_tag);
            for (int x = 0; x < DEPTH; x++) r_older[x][e] <= r_busy[x] | w_lower[i][x];
            r_older[e] <= w_higher[i];
          end
        end
      end
    end
  end

endmodule
